// File: rtl/operand_matcher_stream.sv
// operand_matcher_stream: compacts matched A/W bitmask positions into dense index pairs streamed LANES per beat
module operand_matcher_stream #(
  parameter int BITMASK_LENGTH = 16,
  parameter int INDEX_BITWIDTH = 4,
  parameter int LANES = 4,
  parameter int COUNT_BITWIDTH = 5
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               ivalid,
  output logic                               oready,
  input  logic [BITMASK_LENGTH-1:0]          bitmaskW,
  input  logic [BITMASK_LENGTH-1:0]          bitmaskA,
  output logic                               ovalid,
  input  logic                               iready,
  output logic [LANES*INDEX_BITWIDTH-1:0]    outIndicesA,
  output logic [LANES*INDEX_BITWIDTH-1:0]    outIndicesW,
  output logic [LANES-1:0]                   outLaneValid,
  output logic                               outLast,
  output logic [COUNT_BITWIDTH-1:0]          outPairCount
);
  localparam int BEATS = BITMASK_LENGTH / LANES;
  localparam int KW = BEATS > 1 ? $clog2(BEATS) : 1;
  typedef enum logic [1:0] {IDLE, COMPACT, EMIT} state_t;
  state_t state, state_n;
  logic [BITMASK_LENGTH-1:0] wreg, areg, mreg;
  logic [INDEX_BITWIDTH-1:0] list_a [BITMASK_LENGTH];
  logic [INDEX_BITWIDTH-1:0] list_w [BITMASK_LENGTH];
  logic [INDEX_BITWIDTH-1:0] list_a_n [BITMASK_LENGTH];
  logic [INDEX_BITWIDTH-1:0] list_w_n [BITMASK_LENGTH];
  logic [COUNT_BITWIDTH-1:0] cnt, cnt_n;
  logic [KW-1:0] k, last_k;

  always_ff @(posedge clock)
    if (reset) state <= IDLE;
    else state <= state_n;

  always_comb begin
    state_n = state == IDLE ? (ivalid ? COMPACT : IDLE) :
              state == COMPACT ? EMIT :
              (iready && outLast ? IDLE : EMIT);
  end

  // dense slot of a matched bit p is p minus the unmatched bits below it
  always_comb begin
    logic [INDEX_BITWIDTH-1:0] ca, cw, cn;
    ca = '0;
    cw = '0;
    cn = '0;
    list_a_n = '{default: '0};
    list_w_n = '{default: '0};
    for (int p = 0; p < BITMASK_LENGTH; p++) begin
      if (mreg[p]) begin
        list_a_n[INDEX_BITWIDTH'(p) - cn] = ca;
        list_w_n[INDEX_BITWIDTH'(p) - cn] = cw;
      end
      ca = ca + INDEX_BITWIDTH'(areg[p]);
      cw = cw + INDEX_BITWIDTH'(wreg[p]);
      cn = cn + INDEX_BITWIDTH'(!mreg[p]);
    end
    cnt_n = COUNT_BITWIDTH'($countones(mreg));
  end

  always_ff @(posedge clock)
    if (reset) begin
      wreg <= '0;
      areg <= '0;
      mreg <= '0;
      list_a <= '{default: '0};
      list_w <= '{default: '0};
      cnt <= '0;
      k <= '0;
    end else begin
      if (state == IDLE && ivalid) begin
        wreg <= bitmaskW;
        areg <= bitmaskA;
        mreg <= bitmaskA & bitmaskW;
      end
      if (state == COMPACT) begin
        list_a <= list_a_n;
        list_w <= list_w_n;
        cnt <= cnt_n;
        k <= '0;
      end else if (state == EMIT && iready && !outLast) k <= k + 1'b1;
    end

  always_comb begin
    logic [COUNT_BITWIDTH-1:0] pos;
    pos = '0;
    ovalid = state == EMIT;
    oready = state == IDLE;
    last_k = cnt == '0 ? '0 : KW'((int'(cnt) - 1) / LANES);
    outLast = ovalid && k == last_k;
    outPairCount = ovalid ? cnt : '0;
    outLaneValid = '0;
    outIndicesA = '0;
    outIndicesW = '0;
    for (int l = 0; l < LANES; l++) begin
      pos = COUNT_BITWIDTH'(int'(k) * LANES + l);
      outLaneValid[l] = ovalid && pos < cnt;
      outIndicesA[l*INDEX_BITWIDTH +: INDEX_BITWIDTH] = outLaneValid[l] ? list_a[pos[INDEX_BITWIDTH-1:0]] : '0;
      outIndicesW[l*INDEX_BITWIDTH +: INDEX_BITWIDTH] = outLaneValid[l] ? list_w[pos[INDEX_BITWIDTH-1:0]] : '0;
    end
  end
endmodule

// File: tb/tb_operand_matcher_stream.sv
// tb_operand_matcher_stream: random and directed transactions checked against a popcount-based reference
module tb_operand_matcher_stream;
  logic clock = 0, reset = 1, ivalid = 0, iready = 0;
  logic [15:0] bw = '0, ba = '0;
  logic oready, ovalid, outLast;
  logic [15:0] outIndicesA, outIndicesW;
  logic [3:0] outLaneValid;
  logic [4:0] outPairCount;
  int n_chk = 0, n_pass = 0, n_ov = 0;

  operand_matcher_stream dut (
    .clock(clock), .reset(reset), .ivalid(ivalid), .oready(oready),
    .bitmaskW(bw), .bitmaskA(ba), .ovalid(ovalid), .iready(iready),
    .outIndicesA(outIndicesA), .outIndicesW(outIndicesW),
    .outLaneValid(outLaneValid), .outLast(outLast), .outPairCount(outPairCount)
  );

  always #5 clock = ~clock;
  always @(posedge clock) if (ovalid) n_ov <= n_ov + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_ovalid"}, ovalid, 0);
    chk({tag, "_oready"}, oready, 1);
    chk({tag, "_lanes"}, outLaneValid, 0);
    chk({tag, "_last"}, outLast, 0);
    chk({tag, "_count"}, outPairCount, 0);
    chk({tag, "_idx"}, {outIndicesA, outIndicesW}, 0);
  endtask

  // sb/sn: stall sn cycles on beat sb; rnd: random stalls; hold: leave ivalid high afterwards
  task automatic txn(input logic [15:0] w, input logic [15:0] a, input int sb, input int sn,
                     input bit rnd, input bit hold);
    int qa[$], qw[$];
    int cnt, beats, stalls, ov0;
    logic [15:0] msk;
    for (int p = 0; p < 16; p++)
      if (w[p] && a[p]) begin
        msk = (16'd1 << p) - 16'd1;
        qa.push_back($countones(a & msk));
        qw.push_back($countones(w & msk));
      end
    cnt = qa.size();
    beats = cnt == 0 ? 1 : (cnt + 3) / 4;
    chk("accept_oready", oready, 1);
    bw = w;
    ba = a;
    ivalid = 1;
    iready = 1'($urandom_range(0, 1));
    @(posedge clock); #1;
    if (!hold) ivalid = 0;
    chk("compact_ovalid", ovalid, 0);
    chk("compact_oready", oready, 0);
    ov0 = n_ov;
    stalls = 0;
    @(posedge clock); #1;
    for (int b = 0; b < beats; b++) begin
      int s;
      logic [15:0] ea, ew;
      logic [3:0] ev;
      s = b == sb ? sn : (rnd && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      ea = '0;
      ew = '0;
      ev = '0;
      for (int l = 0; l < 4; l++)
        if (b * 4 + l < cnt) begin
          ea[l*4 +: 4] = 4'(qa[b*4+l]);
          ew[l*4 +: 4] = 4'(qw[b*4+l]);
          ev[l] = 1'b1;
        end
      for (int i = 0; i <= s; i++) begin
        iready = i == s;
        if (!iready) stalls++;
        chk("beat_ovalid", ovalid, 1);
        chk("beat_oready", oready, 0);
        chk("beat_idxA", outIndicesA, ea);
        chk("beat_idxW", outIndicesW, ew);
        chk("beat_lanes", outLaneValid, ev);
        chk("beat_last", outLast, b == beats - 1);
        chk("beat_count", outPairCount, cnt);
        @(posedge clock); #1;
      end
    end
    chk("ovalid_cycles", n_ov - ov0, beats + stalls);
    chk("done_ovalid", ovalid, 0);
    chk("done_oready", oready, 1);
    iready = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    ivalid = 1;
    bw = 16'hFFFF;
    ba = 16'hFFFF;
    repeat (3) @(posedge clock);
    #1;
    reset = 0;
    ivalid = 0;
    check_idle_outputs("reset");
    txn(16'hFFFF, 16'hFFFF, -1, 0, 0, 0);
    txn(16'h00F0, 16'h0FF0, -1, 0, 0, 0);
    txn(16'h8001, 16'h8003, -1, 0, 0, 0);
    txn(16'h5555, 16'hAAAA, -1, 0, 0, 0);
    txn(16'hFFFF, 16'hFFFF, 1, 3, 0, 1);
    txn(16'hFFFF, 16'hFFFF, -1, 0, 0, 0);
    bw = 16'hFFFF;
    ba = 16'hFFFF;
    ivalid = 1;
    iready = 1;
    @(posedge clock); #1;
    ivalid = 0;
    repeat (3) begin @(posedge clock); #1; end
    chk("mid_beat2_lanes", outLaneValid, 4'hF);
    chk("mid_beat2_idxA", outIndicesA, 16'hBA98);
    reset = 1;
    iready = 0;
    @(posedge clock); #1;
    reset = 0;
    check_idle_outputs("midreset");
    txn(16'h0F0F, 16'h3C3C, -1, 0, 0, 0);
    for (int t = 0; t < 40; t++) begin
      logic [15:0] w, a;
      w = 16'($urandom);
      a = 16'($urandom);
      if (t % 5 == 0) a = a | w;
      if (t % 7 == 0) w = w & 16'($urandom);
      txn(w, a, -1, 0, 1, 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
